bin2bcd_seq: RTL and testbench

//  Iterative double-dabble binary-to-BCD converter. Each shift step applies the add-3 correction
//  (a digit of 5..9 becomes digit+3) to every BCD digit, then shifts one binary bit in.

---
 rtl/bin2bcd_seq.sv | 132 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter.
// It shifts one binary bit into the BCD digit scratch per clock, after the
// add-3 correction has been applied to every digit. It feeds the per-digit
// 7-segment decoders and uses a start/busy/done handshake.

module bin2bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Load value for the step counter: one step per binary input bit.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    shiftReg_q, shiftReg_d;
    logic [BCD_W-1:0]    digits_q, digits_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    corrected;
    logic [BCD_W-1:0]    shiftedDigits;
    logic                topBit;

    // The add-3 correction is applied to each digit of the scratch. The
    // corrected digits then shift left by one, taking the top bit of the
    // binary shift register. The bit that leaves the top digit would belong
    // to a digit we do not keep, so it only feeds the overflow flag.
    always_comb begin
        corrected = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digits_q[4*k +: 4] >= 4'd5) begin
                corrected[4*k +: 4] = digits_q[4*k +: 4] + 4'd3;
            end else begin
                corrected[4*k +: 4] = digits_q[4*k +: 4];
            end
        end
        shiftedDigits = {corrected[BCD_W-2:0], shiftReg_q[BIN_W-1]};
        topBit        = corrected[BCD_W-1];
    end

    // Next state for the FSM and the datapath. Start is only accepted in
    // IDLE, so a start during a conversion is dropped and not queued. The
    // result registers change only on the final shift step.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        digits_d   = digits_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shiftReg_d = bin;
                    digits_d   = '0;
                    carry_d    = 1'b0;
                    cnt_d      = CNT_LOAD;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                shiftReg_d = shiftReg_q << 1;
                digits_d   = shiftedDigits;
                carry_d    = carry_q | topBit;
                cnt_d      = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    bcd_d      = shiftedDigits;
                    overflow_d = carry_q | topBit;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. A reset clears everything, which aborts
    // any conversion in progress without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            digits_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            digits_q   <= digits_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and sweep checks of bin2bcd_seq. It uses the
// default 10-bit/4-digit instance, plus a 14-bit instance for the overflow cases.

module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  bin;
    logic        busy, done, overflow;
    logic [15:0] bcd;

    logic        start14;
    logic [13:0] bin14;
    logic        busy14, done14, overflow14;
    logic [15:0] bcd14;

    int checkCount = 0;
    int errorCount = 0;

    bin2bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .bin(bin14),
        .busy(busy14), .done(done14), .bcd(bcd14), .overflow(overflow14)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Timeout guard so that the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference model: repeated division by ten, with bit 16 as the overflow flag.
    function automatic logic [16:0] refBcd(input int value);
        int v = value;
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {v != 0, r};
    endfunction

    // Pulse start with a value, then scramble bin after capture. Latency is
    // the count of negedges from the capture edge until done is seen.
    task automatic applyStimulus(input logic [9:0] value, output int latency,
                                 output int busyCycles);
        bin   = value;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bin   = ~value;
        latency    = -1;
        busyCycles = 0;
        for (int i = 1; i <= 40 && latency < 0; i++) begin
            if (busy) busyCycles++;
            if (done) latency = i;
            else @(negedge clk);
        end
    endtask

    task automatic applyStimulus14(input logic [13:0] value, output int latency);
        bin14   = value;
        start14 = 1'b1;
        @(negedge clk);
        start14 = 1'b0;
        bin14   = ~value;
        latency = -1;
        for (int i = 1; i <= 40 && latency < 0; i++) begin
            if (done14) latency = i;
            else @(negedge clk);
        end
    endtask

    initial begin
        int lat, bc, gap, doneSeen;
        logic [16:0] expv;
        logic [9:0]  vecIn  [4];
        logic [15:0] vecOut [4];

        vecIn[0] = 10'd1023; vecOut[0] = 16'h1023;
        vecIn[1] = 10'd255;  vecOut[1] = 16'h0255;
        vecIn[2] = 10'd999;  vecOut[2] = 16'h0999;
        vecIn[3] = 10'd5;    vecOut[3] = 16'h0005;

        rst = 1'b1; start = 1'b0; bin = '0; start14 = 1'b0; bin14 = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_bcd", bcd, 0);
        checkOutput("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: zero, including busy duration and latency.
        applyStimulus(10'd0, lat, bc);
        checkOutput("t1_latency", lat, 11);
        checkOutput("t1_busy_cycles", bc, 10);
        checkOutput("t1_bcd", bcd, 16'h0000);
        checkOutput("t1_ovf", overflow, 0);
        @(negedge clk);
        checkOutput("t1_done_width", done, 0);

        // Test 2: directed values.
        for (int n = 0; n < 4; n++) begin
            applyStimulus(vecIn[n], lat, bc);
            checkOutput("t2_latency", lat, 11);
            checkOutput("t2_bcd", bcd, vecOut[n]);
            checkOutput("t2_ovf", overflow, 0);
            @(negedge clk);
            checkOutput("t2_done_width", done, 0);
            checkOutput("t2_bcd_hold", bcd, vecOut[n]);
        end

        // Test 3: a start while busy is ignored.
        bin = 10'd300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        bin = 10'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 4; i <= 40 && lat < 0; i++) begin
            if (done) lat = i;
            else @(negedge clk);
        end
        checkOutput("t3_latency", lat, 11);
        checkOutput("t3_bcd", bcd, 16'h0300);
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("t3_extra_done", doneSeen, 0);
        checkOutput("t3_busy", busy, 0);

        // Test 4: start held high repeats conversions back to back.
        bin = 10'd512; start = 1'b1;
        lat = -1;
        for (int i = 0; i <= 40 && lat < 0; i++) begin
            @(negedge clk);
            if (done) lat = i;
        end
        checkOutput("t4_first_done", (lat >= 0), 1);
        checkOutput("t4_bcd", bcd, 16'h0512);
        for (int r = 0; r < 3; r++) begin
            gap = -1;
            for (int i = 1; i <= 30 && gap < 0; i++) begin
                @(negedge clk);
                if (done) gap = i;
            end
            checkOutput("t4_gap", gap, 11);
            checkOutput("t4_bcd_rep", bcd, 16'h0512);
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput("t4_idle", busy, 0);

        // Test 5: reset mid-conversion aborts it.
        bin = 10'd700; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_done", done, 0);
        checkOutput("t5_bcd", bcd, 16'h0000);
        doneSeen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("t5_no_done", doneSeen, 0);
        applyStimulus(10'd42, lat, bc);
        checkOutput("t5_latency", lat, 11);
        checkOutput("t5_bcd_after", bcd, 16'h0042);

        // Test 6: 14-bit instance with overflow boundaries.
        applyStimulus14(14'd16383, lat);
        checkOutput("t6_latency", lat, 15);
        checkOutput("t6_bcd_16383", bcd14, 16'h6383);
        checkOutput("t6_ovf_16383", overflow14, 1);
        applyStimulus14(14'd9999, lat);
        checkOutput("t6_bcd_9999", bcd14, 16'h9999);
        checkOutput("t6_ovf_9999", overflow14, 0);
        applyStimulus14(14'd10000, lat);
        checkOutput("t6_bcd_10000", bcd14, 16'h0000);
        checkOutput("t6_ovf_10000", overflow14, 1);
        @(negedge clk);
        checkOutput("t6_done_width", done14, 0);

        // Sweep all 10-bit inputs against the reference model.
        for (int v = 0; v < 1024; v++) begin
            expv = refBcd(v);
            applyStimulus(10'(v), lat, bc);
            checkOutput("sweep_latency", lat, 11);
            checkOutput("sweep_bcd", bcd, expv[15:0]);
            checkOutput("sweep_ovf", overflow, expv[16]);
            @(negedge clk);
            checkOutput("sweep_done_width", done, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
